// File: rtl/h2bp.sv
// Shared fetch-stage types and constants.
package h2bp;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of {pc, instr} entries; head is registered, so push-to-visible takes 1 cycle.
// Push and pop may coincide at any occupancy; flush empties the buffer at the next edge.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full buffer can still accept a word when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word requests, buffers responses for the decoder.
// Requests stall when outstanding + buffered reaches FIFO_DEPTH; redirects flush and drain stale responses.
module fetch_unit
  import h2bp::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] STEP    = 32'(INSTR_BYTES);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [63:0]   fifo_head;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_tgt;
  logic          req_fire, redirect_eff;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign redirect_eff = redirect_valid && (state_q != BOOT);

  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = (state_q == RUN) && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fifo_push = (state_q == RUN) && imem_resp_valid && !redirect_eff;
  assign fifo_pop  = instr_valid && instr_ready && !redirect_eff;

  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_head[63:32];
  assign instr       = fifo_head[31:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (req_fire)  pc_d      = pc_q + STEP;
        if (fifo_push) resp_pc_d = resp_pc_q + STEP;
      end
      DRAIN: begin
        if (imem_resp_valid) drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_d == '0) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_eff) begin
      pc_d       = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d == '0) ? RUN : DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (fifo_push),
    .push_dat_i({resp_pc_q, imem_resp_data}),
    .pop_i     (fifo_pop),
    .flush_i   (redirect_eff),
    .head_dat_o(fifo_head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && outstanding_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
